// File: rtl/io_map_pkg.sv
// Shared I/O map for the core's peripheral window: data-memory addresses
// (AVR I/O address 0x20+k maps to 14'h2000 + 4*k) and external-interrupt sense encodings.
package io_map_pkg;

    localparam logic [13:0] PINB_ADDR   = 14'h200C;
    localparam logic [13:0] PORTB_ADDR  = 14'h2014;
    localparam logic [13:0] PIND_ADDR   = 14'h2024;
    localparam logic [13:0] PORTD_ADDR  = 14'h202C;
    localparam logic [13:0] TIFR0_ADDR  = 14'h2054;
    localparam logic [13:0] EIFR_ADDR   = 14'h2070;
    localparam logic [13:0] EIMSK_ADDR  = 14'h2074;
    localparam logic [13:0] TCCR0A_ADDR = 14'h2090;
    localparam logic [13:0] TCCR0B_ADDR = 14'h2094;
    localparam logic [13:0] TCNT0_ADDR  = 14'h2098;
    localparam logic [13:0] OCR0A_ADDR  = 14'h209C;
    localparam logic [13:0] EICRA_ADDR  = 14'h2124;
    localparam logic [13:0] TIMSK0_ADDR = 14'h2138;

    localparam logic [1:0] ISC_LOW  = 2'b00;
    localparam logic [1:0] ISC_ANY  = 2'b01;
    localparam logic [1:0] ISC_FALL = 2'b10;
    localparam logic [1:0] ISC_RISE = 2'b11;

endpackage

// File: rtl/ext_int_sense.sv
// One external-interrupt channel: edge/level detection, EIFR flag and registered request.
// Flag priority: level mode or mode change forces 0, then event sets, then W1C/ack clears.
module ext_int_sense
    import io_map_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       pin_s,
    input  logic       pin_q,
    input  logic [1:0] mode,
    input  logic       clr,
    input  logic       ack,
    input  logic       flush,
    input  logic       mask,
    output logic       flag,
    output logic       request
);

    logic edge_event;

    always_comb begin
        edge_event = 1'b0;
        case (mode)
            ISC_ANY:  edge_event = pin_q ^ pin_s;
            ISC_FALL: edge_event = pin_q & ~pin_s;
            ISC_RISE: edge_event = ~pin_q & pin_s;
            default:  edge_event = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flag    <= 1'b0;
            request <= 1'b0;
        end else begin
            // A same-cycle EICRA write discards any event seen under the old mode.
            if (mode == ISC_LOW || flush)
                flag <= 1'b0;
            else if (edge_event)
                flag <= 1'b1;
            else if (clr || ack)
                flag <= 1'b0;

            if (mode == ISC_LOW)
                request <= ~pin_s & mask;
            else
                request <= flag & mask;
        end
    end

endmodule

// File: rtl/ext_int_input_responder.sv
// PIND synchroniser, INT0/INT1 sensing, EICRA/EIFR registers and a 1-cycle-latency read port.
// Read data is registered; no backpressure, valid is a single-cycle beat per hit read.
module ext_int_input_responder
    import io_map_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDRESS_BITS = 32,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [13:0] PIND_ADDR    = io_map_pkg::PIND_ADDR,
    parameter logic [13:0] EIFR_ADDR    = io_map_pkg::EIFR_ADDR,
    parameter logic [13:0] EICRA_ADDR   = io_map_pkg::EICRA_ADDR
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              PIND_in,
    input  logic [1:0]              EIMSK,
    input  logic                    d_mem_read,
    input  logic                    d_mem_write,
    input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
    input  logic [1:0]              int_ack,
    output logic                    io_hit,
    output logic                    io_valid,
    output logic [DATA_WIDTH-1:0]   io_data_out,
    output logic [1:0]              int_request
);

    logic [7:0]  sync_q [SYNC_STAGES];
    logic [7:0]  pin_s;
    logic [7:0]  pin_q;
    logic [3:0]  eicra;
    logic [1:0]  eifr;
    logic [13:0] addr;
    logic        eicra_wr;
    logic        eifr_wr;
    logic [7:0]  rd_byte;
    logic        unused_bits;

    assign addr        = d_mem_address_in[13:0];
    assign unused_bits = ^{d_mem_address_in[ADDRESS_BITS-1:14], d_mem_data_in[DATA_WIDTH-1:8]};

    // Pins idle high (active-low buttons), so the chain resets to all ones.
    generate
        for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
            always_ff @(posedge clock) begin
                if (reset)
                    sync_q[i] <= 8'hFF;
                else if (i == 0)
                    sync_q[i] <= PIND_in;
                else
                    sync_q[i] <= sync_q[(i == 0) ? 0 : i-1];
            end
        end
    endgenerate

    assign pin_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset)
            pin_q <= 8'hFF;
        else
            pin_q <= pin_s;
    end

    assign eicra_wr = d_mem_write && (addr == EICRA_ADDR);
    assign eifr_wr  = d_mem_write && (addr == EIFR_ADDR);

    always_ff @(posedge clock) begin
        if (reset)
            eicra <= 4'h0;
        else if (eicra_wr)
            eicra <= d_mem_data_in[3:0];
    end

    ext_int_sense u_int0 (
        .clock   (clock),
        .reset   (reset),
        .pin_s   (pin_s[2]),
        .pin_q   (pin_q[2]),
        .mode    (eicra[1:0]),
        .clr     (eifr_wr & d_mem_data_in[0]),
        .ack     (int_ack[0]),
        .flush   (eicra_wr),
        .mask    (EIMSK[0]),
        .flag    (eifr[0]),
        .request (int_request[0])
    );

    ext_int_sense u_int1 (
        .clock   (clock),
        .reset   (reset),
        .pin_s   (pin_s[3]),
        .pin_q   (pin_q[3]),
        .mode    (eicra[3:2]),
        .clr     (eifr_wr & d_mem_data_in[1]),
        .ack     (int_ack[1]),
        .flush   (eicra_wr),
        .mask    (EIMSK[1]),
        .flag    (eifr[1]),
        .request (int_request[1])
    );

    assign io_hit = d_mem_read &&
                    ((addr == PIND_ADDR) || (addr == EIFR_ADDR) || (addr == EICRA_ADDR));

    always_comb begin
        rd_byte = 8'h00;
        if (addr == PIND_ADDR)
            rd_byte = pin_s;
        else if (addr == EIFR_ADDR)
            rd_byte = {6'b0, eifr};
        else if (addr == EICRA_ADDR)
            rd_byte = {4'b0, eicra};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_valid    <= 1'b0;
            io_data_out <= '0;
        end else begin
            io_valid <= io_hit;
            if (io_hit)
                io_data_out <= {{(DATA_WIDTH-8){1'b0}}, rd_byte};
        end
    end

endmodule

// File: tb/tb_ext_int_input_responder.sv
// Directed bench for ext_int_input_responder: reset, reads, edge/level sensing, collisions.
module tb_ext_int_input_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  PIND_in;
    logic [1:0]  EIMSK;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [31:0] d_mem_address_in;
    logic [31:0] d_mem_data_in;
    logic [1:0]  int_ack;
    logic        io_hit;
    logic        io_valid;
    logic [31:0] io_data_out;
    logic [1:0]  int_request;

    int n_cmp = 0;
    int n_err = 0;

    ext_int_input_responder dut (
        .clock            (clock),
        .reset            (reset),
        .PIND_in          (PIND_in),
        .EIMSK            (EIMSK),
        .d_mem_read       (d_mem_read),
        .d_mem_write      (d_mem_write),
        .d_mem_address_in (d_mem_address_in),
        .d_mem_data_in    (d_mem_data_in),
        .int_ack          (int_ack),
        .io_hit           (io_hit),
        .io_valid         (io_valid),
        .io_data_out      (io_data_out),
        .int_request      (int_request)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read at a register address and check the beat returned after one edge.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        d_mem_read       = 1'b1;
        d_mem_address_in = a;
        #1;
        chk({tag, "_hit"}, {31'b0, io_hit}, 32'd1);
        tick();
        d_mem_read = 1'b0;
        chk({tag, "_vld"}, {31'b0, io_valid}, 32'd1);
        chk({tag, "_dat"}, io_data_out, exp);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        d_mem_write      = 1'b1;
        d_mem_address_in = a;
        d_mem_data_in    = d;
        tick();
        d_mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PIND_in = 8'hFF; EIMSK = 2'b00; int_ack = 2'b00;
        d_mem_read = 1'b0; d_mem_write = 1'b0;
        d_mem_address_in = 32'h0; d_mem_data_in = 32'h0;
        tick(2);
        chk("rst_vld", {31'b0, io_valid}, 32'd0);
        chk("rst_dat", io_data_out, 32'h0);
        chk("rst_req", {30'b0, int_request}, 32'd0);
        reset = 1'b0;

        // Reset then read PIND and EIFR
        PIND_in = 8'hA5;
        tick(3);
        do_read("pind_a5", 32'h2024, 32'h000000A5);
        tick();
        chk("vld_one_cycle", {31'b0, io_valid}, 32'd0);
        do_read("eifr_rst", 32'h2070, 32'h0);
        d_mem_read = 1'b1; d_mem_address_in = 32'h2028;
        #1;
        chk("nohit_hit", {31'b0, io_hit}, 32'd0);
        tick();
        d_mem_read = 1'b0;
        chk("nohit_vld", {31'b0, io_valid}, 32'd0);
        chk("nohit_hold", io_data_out, 32'h0);
        do_write(32'h2024, 32'h00);
        do_read("pind_ro", 32'h2024, 32'h000000A5);
        PIND_in = 8'hFF;
        tick(4);

        // Falling edge on INT0
        do_write(32'h2124, 32'h02);
        EIMSK = 2'b01;
        PIND_in = 8'hFB;
        tick(3);
        chk("fall_req_c3", {30'b0, int_request}, 32'd0);
        do_read("fall_eifr", 32'h2070, 32'h01);
        chk("fall_req_c4", {30'b0, int_request}, 32'd1);
        do_write(32'h2070, 32'h01);
        do_read("fall_clr_eifr", 32'h2070, 32'h00);
        chk("fall_clr_req", {30'b0, int_request}, 32'd0);
        PIND_in = 8'hFF;
        tick(4);
        do_read("fall_rise_ignored", 32'h2070, 32'h00);

        // Rising edge on INT1, masked then unmasked, then acked
        do_write(32'h2124, 32'h0C);
        EIMSK = 2'b00;
        PIND_in = 8'hF7;
        tick(3);
        PIND_in = 8'hFF;
        tick(3);
        do_read("rise_eifr", 32'h2070, 32'h02);
        chk("rise_req_masked", {30'b0, int_request}, 32'd0);
        EIMSK = 2'b10;
        tick();
        chk("rise_req_unmask", {30'b0, int_request}, 32'd2);
        int_ack = 2'b10;
        tick();
        int_ack = 2'b00;
        tick();
        chk("rise_ack_req", {30'b0, int_request}, 32'd0);
        do_read("rise_ack_eifr", 32'h2070, 32'h00);

        // W1C colliding with a new INT0 event: set wins
        do_write(32'h2124, 32'h02);
        EIMSK = 2'b01;
        PIND_in = 8'hFB;
        tick(2);
        do_write(32'h2070, 32'h01);
        do_read("coll_eifr", 32'h2070, 32'h01);
        do_write(32'h2070, 32'h01);
        PIND_in = 8'hFF;
        tick(4);
        // EICRA write colliding with an event: event discarded
        PIND_in = 8'hFB;
        tick(2);
        do_write(32'h2124, 32'h02);
        do_read("modechg_eifr", 32'h2070, 32'h00);
        do_read("modechg_eicra", 32'h2124, 32'h02);

        // Level mode on INT0
        do_write(32'h2124, 32'h00);
        PIND_in = 8'hFF;
        tick(4);
        chk("lvl_idle_req", {30'b0, int_request}, 32'd0);
        PIND_in = 8'hFB;
        tick(2);
        chk("lvl_req_c2", {30'b0, int_request}, 32'd0);
        tick();
        chk("lvl_req_c3", {30'b0, int_request}, 32'd1);
        int_ack = 2'b01;
        tick();
        int_ack = 2'b00;
        chk("lvl_ack_req", {30'b0, int_request}, 32'd1);
        do_read("lvl_eifr", 32'h2070, 32'h00);
        PIND_in = 8'hFF;
        tick(2);
        chk("lvl_rel_c2", {30'b0, int_request}, 32'd1);
        tick();
        chk("lvl_rel_c3", {30'b0, int_request}, 32'd0);

        // Reset after a read, read during reset, then back-to-back reads
        d_mem_read = 1'b1; d_mem_address_in = 32'h2024;
        tick();
        d_mem_read = 1'b0;
        reset = 1'b1;
        chk("prerst_vld", {31'b0, io_valid}, 32'd1);
        tick();
        chk("rst_mid_vld", {31'b0, io_valid}, 32'd0);
        chk("rst_mid_dat", io_data_out, 32'h0);
        d_mem_read = 1'b1;
        tick();
        d_mem_read = 1'b0;
        chk("rst_read_vld", {31'b0, io_valid}, 32'd0);
        reset = 1'b0;
        do_read("rst_eicra", 32'h2124, 32'h00);
        do_write(32'h2124, 32'h0D);
        PIND_in = 8'h5A;
        tick(3);
        d_mem_read = 1'b1; d_mem_address_in = 32'h2024;
        tick();
        chk("b2b_1_vld", {31'b0, io_valid}, 32'd1);
        chk("b2b_1_dat", io_data_out, 32'h5A);
        d_mem_address_in = 32'h2070;
        tick();
        chk("b2b_2_vld", {31'b0, io_valid}, 32'd1);
        chk("b2b_2_dat", io_data_out, 32'h01);
        d_mem_address_in = 32'h2124;
        tick();
        d_mem_read = 1'b0;
        chk("b2b_3_vld", {31'b0, io_valid}, 32'd1);
        chk("b2b_3_dat", io_data_out, 32'h0D);
        tick();
        chk("b2b_end_vld", {31'b0, io_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ext_int_input_responder.md
# ext_int_input_responder

Read-side companion to the core's write-only peripheral decode. The block synchronises the PIND pins and detects INT0 (PD2) and INT1 (PD3) events. It holds the EICRA and EIFR registers and returns PIND, EIFR and EICRA on core data-memory reads with one-cycle latency. It sits beside the PORTB/PORTD/EIMSK/timer registers on the `d_mem_*` bus. Its `int_request` outputs replace the combinational `I_request` selection feeding `Interrupt_Handler`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width; read data is zero-extended from 8 bits.
- `ADDRESS_BITS`, 32, address bus width; only bits [13:0] are decoded.
- `SYNC_STAGES`, 2, synchroniser depth for PIND; minimum 2.
- `PIND_ADDR`, 14'h2024, PIND read address (AVR 0x29); read-only.
- `EIFR_ADDR`, 14'h2070, EIFR address (AVR 0x3C); read, write-1-to-clear.
- `EICRA_ADDR`, 14'h2124, EICRA address (AVR 0x69); read/write.

Ports:
- `clock` in 1: the single clock (the divided core clock).
- `reset` in 1: synchronous, active-high.
- `PIND_in` in 8: asynchronous pins.
- `EIMSK` in 2: bits [1:0] of the existing EIMSK register.
- `d_mem_read` in 1: core read strobe.
- `d_mem_write` in 1: core write strobe.
- `d_mem_address_in` in ADDRESS_BITS: access address.
- `d_mem_data_in` in DATA_WIDTH: write data; only [7:0] is used.
- `int_ack` in 2: one-cycle pulse from the interrupt handler on vector entry.
- `io_hit` out 1: combinational; the current address matches one of the three addresses and `d_mem_read` is high.
- `io_valid` out 1: registered; read data is valid.
- `io_data_out` out DATA_WIDTH: registered read data.
- `int_request` out 2: registered interrupt requests for INT1 and INT0.

## Operation
- **Synchroniser:** each `PIND_in` bit passes through a `SYNC_STAGES` flop chain. `pin_s` is the last stage; `pin_q` is `pin_s` delayed one cycle.
- **EICRA[3:0]:** ISC01:00 selects the INT0 sense mode and ISC11:10 the INT1 mode.
  - 00 = low level
  - 01 = any change
  - 10 = falling edge
  - 11 = rising edge
  - EICRA bits [7:4] read as 0.
- **Event detection (INTn, where pin = PD2 for n=0, PD3 for n=1):**
  - falling: `pin_q=1 && pin_s=0`
  - rising: `pin_q=0 && pin_s=1`
  - any change: `pin_q != pin_s`
- **EIFR[n] in edge modes:**
  - set on an event;
  - cleared by writing 1 to bit n of `EIFR_ADDR`;
  - cleared by `int_ack[n]`.
  - If a set and a clear land in the same cycle, the set wins.
- **EIFR[n] in level mode:** held at 0; no latching.
- **Mode change:** writing EICRA clears EIFR[1:0]. Any event detected in that same cycle is discarded.
- **`int_request[n]` (registered):**
  - edge modes: `EIFR[n] & EIMSK[n]`;
  - level mode: `~pin_s[n+2] & EIMSK[n]`.
- **Read mux:**
  - `PIND_ADDR` returns `pin_s`;
  - `EIFR_ADDR` returns {6'b0, EIFR};
  - `EICRA_ADDR` returns {4'b0, EICRA}.
  - A read samples register values before any same-cycle update.
- **Ignored accesses:** writes to `PIND_ADDR` have no effect. Accesses to non-matching addresses leave all state unchanged.

## Timing
- **Reset values:**
  - all synchroniser stages and `pin_q`: 8'hFF (idle-high, active-low buttons);
  - EICRA = 0, EIFR = 0;
  - `int_request` = 0, `io_valid` = 0, `io_data_out` = 0.
- **Read latency:** a read in cycle T gives `io_valid`=1 and data in cycle T+1, held for exactly one cycle. Back-to-back reads produce back-to-back valid beats. No backpressure.
- **Non-hit read:** `io_valid` stays 0 and `io_data_out` holds its last value.
- **Pin-to-flag latency:** a pin edge is visible in `pin_s` after `SYNC_STAGES` cycles. EIFR sets on the next edge of `clock`, and `int_request` follows one cycle later. Total for `SYNC_STAGES`=2 is 4 cycles, including the `pin_q` compare cycle.
- **Pulse width:** pulses shorter than one `clock` period may be missed; this is not guaranteed.
- **Pin held low across reset release:**
  - falling-edge mode cannot be active, because EICRA is 0 after reset;
  - level mode with EIMSK set asserts the request once `pin_s` goes low.
- **Reset mid-operation:** reset in any cycle clears EIFR, EICRA and a pending `io_valid` on the next edge. A read issued in the reset cycle returns nothing.

## Structure
- **Shared package `io_map_pkg`:**
  - the address localparams for PINB/PIND/EIFR/EIMSK/EICRA;
  - the existing PORTB/PORTD/timer addresses;
  - the ISC encodings (ISC_LOW, ISC_ANY, ISC_FALL, ISC_RISE).
- **One sub-module `ext_int_sense`,** instantiated twice: inputs `pin_s`, `pin_q`, 2-bit mode, `clr`, `ack`, `mask`; outputs the flag and the request.
- The synchroniser is inline generate logic, not a separate module.
- The top level ORs `io_valid`/`io_data_out` into the load-return path, gated by the registered `io_hit`.

## Test plan
- **Reset then read:** reset, then read 0x2024 with pins 8'hA5 stable for 3 cycles -> `io_valid` one cycle later, data 32'h000000A5; EIFR read -> 0.
- **Falling edge, INT0:** EICRA=8'h02, EIMSK=2'b01, drive PD2 1->0 -> EIFR=2'b01 at cycle 3 and `int_request`=2'b01 at cycle 4; write 8'h01 to 0x2070 -> both 0 next cycle.
- **Rising edge, INT1:** EICRA=8'h0C, PD3 rising with EIMSK=0 -> EIFR reads 2'b10 and `int_request`=0; then set EIMSK=2'b10 -> request 1 next cycle.
- **Clear collision:** a W1C write to EIFR in the same cycle as a new INT0 event -> EIFR[0] remains 1.
- **Level mode:** EICRA=0, EIMSK=2'b01, PD2 held low -> request follows the pin with 3-cycle lag, EIFR stays 0; `int_ack` has no effect.
- **Reset and back-to-back reads:** assert reset in the cycle after a PIND read -> `io_valid`=0; then read PIND, EIFR, EICRA on consecutive cycles -> three consecutive valid beats in order.
